cl_seq_mult_ctrl: RTL and testbench

CL_SEQ_MULT_CTRL -- requirements
Module: cl_seq_mult_ctrl

---
 rtl/cl_seq_mult_ctrl_pkg.sv | 12 +
 rtl/cl_rca_adder.sv | 26 ++
 rtl/cl_seq_mult_ctrl.sv | 93 +++++++++
 tb/tb_cl_seq_mult_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cl_seq_mult_ctrl_pkg.sv
// Shared types and constants for the sequential integer / carry-less multiplier.
package cl_seq_mult_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cl_rca_adder.sv
// Ripple-carry adder that drops to a pure XOR (GF(2) add) when carry_option is 0.
module cl_rca_adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_option,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  co
);

  logic c;

  // NOTE: blocking assignments inside always_comb let the carry ripple bit by
  // bit within one evaluation; every output gets a default first so no latch forms.
  always_comb begin
    sum = '0;
    c   = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = carry_option & ((a[i] & b[i]) | (c & (a[i] ^ b[i])));
    end
    co = c;
  end

endmodule

// File: rtl/cl_seq_mult_ctrl.sv
// Shift-and-add multiplier: N RUN cycles per product, integer or carry-less mode.
module cl_seq_mult_ctrl
  import cl_seq_mult_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    carry_option,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  state_t                state, next_state;
  logic [PW-1:0]         mcand;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         sum;
  logic [DATA_WIDTH-1:0] mplier;
  logic                  mode;
  logic [CW-1:0]         count;
  logic                  accept;

  assign accept  = start && (state != RUN);
  assign product = acc;

  // Carry-out is meaningless here: an N x N product always fits in 2N bits.
  cl_rca_adder #(
    .DATA_WIDTH   (PW)
  ) u_adder (
    .a            (acc),
    .b            (mcand),
    .carry_option (mode),
    .sum          (sum),
    .co           ()
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = accept ? RUN : IDLE;
      RUN:     next_state = (count == CW'(DATA_WIDTH - 1)) ? DONE : RUN;
      DONE:    next_state = accept ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: fixed N steps, no early exit, so latency never depends on operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      mode   <= 1'b0;
      acc    <= '0;
      count  <= '0;
    end else if (accept) begin
      mcand  <= {{DATA_WIDTH{1'b0}}, a};
      mplier <= b;
      mode   <= carry_option;
      acc    <= '0;
      count  <= '0;
    end else if (state == RUN) begin
      if (mplier[0]) acc <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: tb/tb_cl_seq_mult_ctrl.sv
// Directed bench for cl_seq_mult_ctrl at N=8 with hand-computed products.
module tb_cl_seq_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        carry_option;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_cmp = 0;
  int n_mis = 0;

  cl_seq_mult_ctrl #(
    .DATA_WIDTH   (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .carry_option (carry_option),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; carry_option = 1'b0; a = '0; b = '0;
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (product !== 16'h0000) begin n_mis++; $display("FAIL reset_product: got %h expected 0000", product); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full operation: checks busy in RUN, latency N+1, product, done pulse width and hold.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tm,
                        input logic [15:0] exp, input string name);
    int lat;
    @(negedge clk); a = ta; b = tbv; carry_option = tm; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat = 1;
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL %s_busy: got %b expected 1", name, busy); end
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 9) begin n_mis++; $display("FAIL %s_latency: got %0d expected 9", name, lat); end
    n_cmp++; if (product !== exp) begin n_mis++; $display("FAIL %s_product: got %h expected %h", name, product, exp); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL %s_busy_done: got %b expected 0", name, busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL %s_done_width: got %b expected 0", name, done); end
    n_cmp++; if (product !== exp) begin n_mis++; $display("FAIL %s_hold: got %h expected %h", name, product, exp); end
  endtask

  task automatic test_carryless();
    run_op(8'h53, 8'hCA, 1'b0, 16'h3F7E, "clmul_53_ca");
    run_op(8'hFF, 8'hFF, 1'b0, 16'h5555, "clmul_ff_ff");
  endtask

  task automatic test_integer();
    run_op(8'h53, 8'hCA, 1'b1, 16'h417E, "mul_53_ca");
    run_op(8'hFF, 8'hFF, 1'b1, 16'hFE01, "mul_ff_ff");
  endtask

  task automatic test_zero_identity();
    run_op(8'h00, 8'hFF, 1'b1, 16'h0000, "mul_zero");
    run_op(8'hA5, 8'h01, 1'b0, 16'h00A5, "clmul_ident");
    run_op(8'hA5, 8'h01, 1'b1, 16'h00A5, "mul_ident");
  endtask

  task automatic test_start_ignored();
    int cyc;
    int ndone;
    int t_done;
    logic [15:0] p_done;
    @(negedge clk); a = 8'h53; b = 8'hCA; carry_option = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1; ndone = 0; t_done = 0; p_done = '0;
    while (cyc < 22) begin
      if (cyc == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; carry_option = 1'b0; end
      if (cyc == 5) start = 1'b0;
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin t_done = cyc; p_done = product; end
      end
    end
    n_cmp++; if (ndone !== 1) begin n_mis++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    n_cmp++; if (t_done !== 9) begin n_mis++; $display("FAIL ignore_latency: got %0d expected 9", t_done); end
    n_cmp++; if (p_done !== 16'h417E) begin n_mis++; $display("FAIL ignore_product: got %h expected 417e", p_done); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ndone;
    int t0;
    int t1;
    logic [15:0] p0;
    logic [15:0] p1;
    @(negedge clk); a = 8'h53; b = 8'hCA; carry_option = 1'b1; start = 1'b1;
    @(posedge clk); #1; a = 8'hFF; b = 8'hFF;
    cyc = 1; ndone = 0; t0 = 0; t1 = 0; p0 = '0; p1 = '0;
    while (ndone < 2 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (ndone == 1 && start) begin
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL b2b_restart_busy: got %b expected 1", busy); end
      end
      if (done === 1'b1) begin
        if (ndone == 0) begin t0 = cyc; p0 = product; end
        else begin t1 = cyc; p1 = product; end
        ndone++;
      end
    end
    start = 1'b0;
    n_cmp++; if (ndone !== 2) begin n_mis++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    n_cmp++; if (t0 !== 9) begin n_mis++; $display("FAIL b2b_first_latency: got %0d expected 9", t0); end
    n_cmp++; if (t1 - t0 !== 9) begin n_mis++; $display("FAIL b2b_spacing: got %0d expected 9", t1 - t0); end
    n_cmp++; if (p0 !== 16'h417E) begin n_mis++; $display("FAIL b2b_product0: got %h expected 417e", p0); end
    n_cmp++; if (p1 !== 16'hFE01) begin n_mis++; $display("FAIL b2b_product1: got %h expected fe01", p1); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    @(negedge clk); a = 8'h53; b = 8'hCA; carry_option = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL midrst_done: got %b expected 0", done); end
    n_cmp++; if (product !== 16'h0000) begin n_mis++; $display("FAIL midrst_product: got %h expected 0000", product); end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1) ndone++; end
    n_cmp++; if (ndone !== 0) begin n_mis++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
    run_op(8'hFF, 8'hFF, 1'b0, 16'h5555, "post_reset");
  endtask

  initial begin
    test_reset();
    test_carryless();
    test_integer();
    test_zero_identity();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
